// File: rtl/picobus_pkg.sv
// picobus_pkg: shared FSM encodings, default error data and window packing helper for the picobus decoder
package picobus_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
  // Places a 32-bit base or mask word into slot idx of a packed window vector; OR the results together.
  function automatic logic [511:0] slv_win(input int idx, input logic [31:0] word);
    return 512'(word) << (32 * idx);
  endfunction
endpackage

// File: rtl/picobus_addr_match.sv
// picobus_addr_match: combinational base/mask window compare, lowest matching slave wins
module picobus_addr_match import picobus_pkg::*; #(
  parameter int                     NSLV     = 6,
  parameter logic [NSLV*32-1:0]     SLV_BASE = '0,
  parameter logic [NSLV*32-1:0]     SLV_MASK = '0
) (
  input  logic [31:0]     addr,
  output logic            hit,
  output logic [NSLV-1:0] sel
);
  logic [NSLV-1:0] raw;
  for (genvar g = 0; g < NSLV; g++) begin : g_win
    assign raw[g] = (addr & SLV_MASK[32*g +: 32]) == SLV_BASE[32*g +: 32];
  end
  assign hit = |raw;
  assign sel = raw & (~raw + 1'b1);
endmodule

// File: rtl/picobus_decoder.sv
// picobus_decoder: one-master / N-slave picorv32 bus decoder with error response; PICOBUS_TIMEOUT_EN adds a stall watchdog
module picobus_decoder import picobus_pkg::*; #(
  parameter int                 NSLV           = 6,
  parameter logic [NSLV*32-1:0] SLV_BASE       = '0,
  parameter logic [NSLV*32-1:0] SLV_MASK       = '0,
  parameter logic [31:0]        ERR_DATA       = ERR_DATA_DEFAULT,
  parameter int                 TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 m_valid,
  input  logic                 m_instr,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  input  logic [3:0]           m_wstrb,
  output logic                 m_ready,
  output logic [31:0]          m_rdata,
  output logic                 m_err,
  output logic [31:0]          err_addr,
  output logic [NSLV-1:0]      s_valid,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  input  logic [NSLV-1:0]      s_ready,
  input  logic [NSLV*32-1:0]   s_rdata
);
  state_t          state, state_n;
  logic [NSLV-1:0] sel, hit_sel;
  logic            hit, err_q, sel_ready, expired;
  logic [31:0]     rdata_sel;
  logic            unused_instr;

  assign unused_instr = m_instr;

  picobus_addr_match #(.NSLV(NSLV), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_match (
    .addr(m_addr),
    .hit (hit),
    .sel (hit_sel)
  );

  assign sel_ready = |(s_ready & sel);
  assign s_valid   = state == ACTIVE ? sel : '0;
  assign m_ready   = state == RESP;
  assign m_err     = m_ready & err_q;

`ifdef PICOBUS_TIMEOUT_EN
  logic [7:0] count;
  assign expired = !sel_ready && count == 8'(TIMEOUT_CYCLES - 1);
  // Watchdog: counts stalled ACTIVE cycles, cleared while idle
  always_ff @(posedge clk)
    if (!resetn || state == IDLE) count <= '0;
    else if (state == ACTIVE && !sel_ready) count <= count + 8'd1;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  // One-hot read mux over the selected slave's data
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NSLV; i++) rdata_sel |= sel[i] ? s_rdata[32*i +: 32] : 32'd0;
  end

  // State register
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= state_n;

  // Next state: accept in IDLE, wait for selected ready or watchdog in ACTIVE, one RESP cycle
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE   ? (m_valid ? (hit ? ACTIVE : RESP) : IDLE)
            : state == ACTIVE ? ((sel_ready || expired) ? RESP : ACTIVE)
            : IDLE;
  end

  // Request capture, slave select and response/error registers
  always_ff @(posedge clk)
    if (!resetn) begin
      sel      <= '0;
      err_q    <= 1'b0;
      m_rdata  <= '0;
      err_addr <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
    end else if (state == IDLE && m_valid) begin
      s_addr  <= m_addr;
      s_wdata <= m_wdata;
      s_wstrb <= m_wstrb;
      sel     <= hit_sel;
      err_q   <= !hit;
      if (!hit) begin
        m_rdata  <= ERR_DATA;
        err_addr <= m_addr;
      end
    end else if (state == ACTIVE && sel_ready) begin
      m_rdata <= rdata_sel;
    end else if (state == ACTIVE && expired) begin
      m_rdata  <= ERR_DATA;
      err_addr <= s_addr;
      err_q    <= 1'b1;
    end
endmodule

// File: tb/tb_picobus_decoder.sv
// tb_picobus_decoder: scoreboard-driven checks of decode, priority, miss, stall, watchdog, reset and back-to-back timing
module tb_picobus_decoder;
  import picobus_pkg::*;
  localparam int N = 6;
  localparam logic [N*32-1:0] BASE = {32'h0400_0000, 32'h0300_0000, 32'h0300_0000,
                                      32'h0200_0008, 32'h0100_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] MASK = {32'hFF00_0000, 32'hFFF0_0000, 32'hFF00_0000,
                                      32'hFFFF_FFFF, 32'hFF00_0000, 32'hFF00_0000};

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             m_valid = 1'b0;
  logic             m_instr = 1'b0;
  logic [31:0]      m_addr = '0;
  logic [31:0]      m_wdata = '0;
  logic [3:0]       m_wstrb = '0;
  logic             m_ready;
  logic [31:0]      m_rdata;
  logic             m_err;
  logic [31:0]      err_addr;
  logic [N-1:0]     s_valid;
  logic [31:0]      s_addr;
  logic [31:0]      s_wdata;
  logic [3:0]       s_wstrb;
  logic [N-1:0]     s_ready = '0;
  logic [N*32-1:0]  s_rdata = '0;

  resp_t sb[$];
  resp_t exp_r;
  int    checks = 0;
  int    errors = 0;

  picobus_decoder #(
    .NSLV(N), .SLV_BASE(BASE), .SLV_MASK(MASK), .ERR_DATA(32'hDEAD_BEEF), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .err_addr(err_addr), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                       input logic [31:0] er, input logic e);
    resp_t r;
    m_valid = 1'b1;
    m_addr  = a;
    m_wstrb = st;
    m_wdata = d;
    r.rdata = er;
    r.err   = e;
    sb.push_back(r);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    checks++; if (s_valid !== '0) begin errors++; $display("FAIL reset_s_valid got %h want 0", s_valid); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_m_ready got %b want 0", m_ready); end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_m_err got %b want 0", m_err); end
    checks++; if (m_rdata !== '0) begin errors++; $display("FAIL reset_m_rdata got %h want 0", m_rdata); end
    checks++; if (err_addr !== '0) begin errors++; $display("FAIL reset_err_addr got %h want 0", err_addr); end
    checks++; if (s_addr !== '0) begin errors++; $display("FAIL reset_s_addr got %h want 0", s_addr); end
    checks++; if (s_wdata !== '0) begin errors++; $display("FAIL reset_s_wdata got %h want 0", s_wdata); end
    checks++; if (s_wstrb !== '0) begin errors++; $display("FAIL reset_s_wstrb got %h want 0", s_wstrb); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_read_slave2();
    issue(32'h0200_0008, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
    step();
    m_valid = 1'b0;
    checks++; if (s_valid !== 6'b000100) begin errors++; $display("FAIL rd2_s_valid got %b want 000100", s_valid); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rd2_early_ready got %b want 0", m_ready); end
    s_ready = 6'b000100;
    s_rdata[95:64] = 32'h1234_5678;
    step();
    s_ready = '0;
    exp_r = sb.pop_front();
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rd2_ready got %b want 1", m_ready); end
    checks++; if (m_rdata !== exp_r.rdata) begin errors++; $display("FAIL rd2_rdata got %h want %h", m_rdata, exp_r.rdata); end
    checks++; if (m_err !== exp_r.err) begin errors++; $display("FAIL rd2_err got %b want %b", m_err, exp_r.err); end
    checks++; if (s_valid !== '0) begin errors++; $display("FAIL rd2_resp_s_valid got %b want 0", s_valid); end
    step();
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rd2_pulse got %b want 0", m_ready); end
  endtask

  task automatic test_priority();
    issue(32'h0300_0000, 4'h0, 32'h0, 32'hA5A5_0003, 1'b0);
    step();
    m_valid = 1'b0;
    checks++; if (s_valid !== 6'b001000) begin errors++; $display("FAIL prio_s_valid got %b want 001000", s_valid); end
    s_ready = 6'b011000;
    s_rdata[127:96]  = 32'hA5A5_0003;
    s_rdata[159:128] = 32'h5A5A_0004;
    step();
    s_ready = '0;
    exp_r = sb.pop_front();
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL prio_ready got %b want 1", m_ready); end
    checks++; if (m_rdata !== exp_r.rdata) begin errors++; $display("FAIL prio_rdata got %h want %h", m_rdata, exp_r.rdata); end
    checks++; if (m_err !== exp_r.err) begin errors++; $display("FAIL prio_err got %b want %b", m_err, exp_r.err); end
    step();
  endtask

  task automatic test_miss_write();
    issue(32'hF000_0000, 4'hF, 32'h1111_2222, 32'hDEAD_BEEF, 1'b1);
    step();
    m_valid = 1'b0;
    exp_r = sb.pop_front();
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL miss_ready got %b want 1", m_ready); end
    checks++; if (m_err !== exp_r.err) begin errors++; $display("FAIL miss_err got %b want %b", m_err, exp_r.err); end
    checks++; if (m_rdata !== exp_r.rdata) begin errors++; $display("FAIL miss_rdata got %h want %h", m_rdata, exp_r.rdata); end
    checks++; if (err_addr !== 32'hF000_0000) begin errors++; $display("FAIL miss_err_addr got %h want f0000000", err_addr); end
    checks++; if (s_valid !== '0) begin errors++; $display("FAIL miss_s_valid got %b want 0", s_valid); end
    step();
    checks++; if (m_ready !== 1'b0 || m_err !== 1'b0) begin errors++; $display("FAIL miss_pulse got %b%b want 00", m_ready, m_err); end
    checks++; if (s_valid !== '0) begin errors++; $display("FAIL miss_s_valid_after got %b want 0", s_valid); end
  endtask

  task automatic test_stall_other_ready();
    issue(32'h0100_0040, 4'b0011, 32'hCAFE_F00D, 32'h0B0B_0001, 1'b0);
    step();
    m_valid = 1'b0;
    checks++; if (s_valid !== 6'b000010) begin errors++; $display("FAIL stall_s_valid got %b want 000010", s_valid); end
    checks++; if (s_addr !== 32'h0100_0040) begin errors++; $display("FAIL stall_s_addr got %h want 01000040", s_addr); end
    checks++; if (s_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL stall_s_wdata got %h want cafef00d", s_wdata); end
    checks++; if (s_wstrb !== 4'b0011) begin errors++; $display("FAIL stall_s_wstrb got %b want 0011", s_wstrb); end
    s_ready = 6'b111101;
    s_rdata[63:32] = 32'h0B0B_0001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL stall_wait%0d got %b want 0", i, m_ready); end
    end
    s_ready = 6'b000010;
    step();
    s_ready = '0;
    exp_r = sb.pop_front();
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL stall_ready got %b want 1", m_ready); end
    checks++; if (m_rdata !== exp_r.rdata) begin errors++; $display("FAIL stall_rdata got %h want %h", m_rdata, exp_r.rdata); end
    checks++; if (m_err !== exp_r.err) begin errors++; $display("FAIL stall_err got %b want %b", m_err, exp_r.err); end
    step();
  endtask

  task automatic test_timeout();
`ifdef PICOBUS_TIMEOUT_EN
    issue(32'h0400_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    step();
    m_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (s_valid !== 6'b100000 || m_ready !== 1'b0) begin errors++; $display("FAIL to_active%0d got %b/%b want 100000/0", i, s_valid, m_ready); end
      step();
    end
    exp_r = sb.pop_front();
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL to_ready got %b want 1", m_ready); end
    checks++; if (m_err !== exp_r.err) begin errors++; $display("FAIL to_err got %b want %b", m_err, exp_r.err); end
    checks++; if (m_rdata !== exp_r.rdata) begin errors++; $display("FAIL to_rdata got %h want %h", m_rdata, exp_r.rdata); end
    checks++; if (err_addr !== 32'h0400_0010) begin errors++; $display("FAIL to_err_addr got %h want 04000010", err_addr); end
    checks++; if (s_valid !== '0) begin errors++; $display("FAIL to_s_valid got %b want 0", s_valid); end
    step();
`else
    int n;
    m_valid = 1'b1;
    m_addr  = 32'h0400_0010;
    m_wstrb = 4'h0;
    step();
    m_valid = 1'b0;
    n = 0;
    while (m_ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL nto_ready got %b after %0d cycles want 0", m_ready, n); end
    checks++; if (s_valid !== 6'b100000) begin errors++; $display("FAIL nto_s_valid got %b want 100000", s_valid); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
`endif
  endtask

  task automatic test_reset_active();
    m_valid = 1'b1;
    m_addr  = 32'h0000_0100;
    m_wstrb = 4'h0;
    step();
    m_valid = 1'b0;
    checks++; if (s_valid !== 6'b000001) begin errors++; $display("FAIL rst_act_s_valid got %b want 000001", s_valid); end
    resetn = 1'b0;
    step();
    checks++; if (s_valid !== '0 || m_ready !== 1'b0) begin errors++; $display("FAIL rst_act_clear got %b/%b want 0/0", s_valid, m_ready); end
    checks++; if (err_addr !== '0 || m_rdata !== '0) begin errors++; $display("FAIL rst_act_regs got %h/%h want 0/0", err_addr, m_rdata); end
    resetn = 1'b1;
    step();
    issue(32'h0000_0100, 4'h0, 32'h0, 32'h7777_0000, 1'b0);
    s_rdata[31:0] = 32'h7777_0000;
    step();
    m_valid = 1'b0;
    s_ready = 6'b000001;
    step();
    s_ready = '0;
    exp_r = sb.pop_front();
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rst_fresh_ready got %b want 1", m_ready); end
    checks++; if (m_rdata !== exp_r.rdata) begin errors++; $display("FAIL rst_fresh_rdata got %h want %h", m_rdata, exp_r.rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_0200, 4'h0, 32'h0, 32'h1000_0001, 1'b0);
    s_rdata[31:0] = 32'h1000_0001;
    s_ready = 6'b000001;
    step();
    checks++; if (s_valid !== 6'b000001) begin errors++; $display("FAIL b2b_s_valid0 got %b want 000001", s_valid); end
    step();
    exp_r = sb.pop_front();
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", m_ready); end
    checks++; if (m_rdata !== exp_r.rdata) begin errors++; $display("FAIL b2b_rdata0 got %h want %h", m_rdata, exp_r.rdata); end
    issue(32'h0100_0004, 4'h0, 32'h0, 32'h2000_0002, 1'b0);
    s_rdata[63:32] = 32'h2000_0002;
    s_ready = 6'b000011;
    step();
    checks++; if (m_ready !== 1'b0 || s_valid !== '0) begin errors++; $display("FAIL b2b_idle got %b/%b want 0/0", m_ready, s_valid); end
    step();
    m_valid = 1'b0;
    checks++; if (s_valid !== 6'b000010) begin errors++; $display("FAIL b2b_s_valid1 got %b want 000010", s_valid); end
    step();
    s_ready = '0;
    exp_r = sb.pop_front();
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", m_ready); end
    checks++; if (m_rdata !== exp_r.rdata) begin errors++; $display("FAIL b2b_rdata1 got %h want %h", m_rdata, exp_r.rdata); end
    checks++; if (m_err !== exp_r.err) begin errors++; $display("FAIL b2b_err1 got %b want %b", m_err, exp_r.err); end
    step();
  endtask

  initial begin
    test_reset();
    test_read_slave2();
    test_priority();
    test_miss_write();
    test_stall_other_ready();
    test_timeout();
    test_reset_active();
    test_back_to_back();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before limit");
    $fatal(1, "simulation time limit");
  end
endmodule
